// File: rtl/dram_pkg.sv
// dram_pkg: field widths, address bit positions and FSM state type shared by
// the DRAM request frontend and its request queue.
package dram_pkg;

  // L2 request layout: {address[ADDR_W-1:0], offset[OFFSET_W-1:0]}
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned OFFSET_W = 9;
  localparam int unsigned L2_REQ_W = ADDR_W + OFFSET_W;

  // Decoded field widths
  localparam int unsigned BANK_W = 3;
  localparam int unsigned ROW_W  = 7;
  localparam int unsigned COL_W  = 3;

  // Field LSB positions inside the address
  localparam int unsigned BANK_LSB = 10;
  localparam int unsigned ROW_LSB  = 3;
  localparam int unsigned COL_LSB  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: circular request queue with occupancy count.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (flushes queue)
//   push_i, wdata_i   write request; ignored when full
//   pop_i, rdata_o    drop head; rdata_o always shows the current head
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
// Depth must be a power of two so the pointers wrap naturally.
module dram_req_fifo #(
  parameter int unsigned Width = 22,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count guards reads of stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dram_req_frontend.sv
// dram_req_frontend: queues L2 requests, decodes them into bank/row/col/offset
// and presents them one at a time to the DRAM controller FSM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   l2_req_valid/_data/_ready  L2 request handshake (ready = queue not full)
//   refresh_flag             refresh pending; blocks new issues
//   addr_val, ctrl_ack       presented request and controller acceptance
//   bank_id/row_id/col_id/offset  decoded fields of the presented request
//   row_hit                  presented row already open in its bank
//   pending_cnt              queued requests, excluding the presented one
// Optional feature: define DRAM_REQ_ROW_HIT_EN to enable per-bank open-row
// tracking; otherwise row_hit is tied low and no tracking state exists.
module dram_req_frontend
  import dram_pkg::*;
#(
  parameter int unsigned L2_REQ_WIDTH = L2_REQ_W,
  parameter int unsigned ADDR_WIDTH   = ADDR_W,
  parameter int unsigned NUM_OF_BANKS = 1 << BANK_W,
  parameter int unsigned NUM_OF_ROWS  = 1 << ROW_W,
  parameter int unsigned NUM_OF_COLS  = 1 << COL_W,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  l2_req_valid,
  input  logic [L2_REQ_WIDTH-1:0]               l2_req_data,
  output logic                                  l2_req_ready,
  input  logic                                  refresh_flag,
  output logic                                  addr_val,
  input  logic                                  ctrl_ack,
  output logic [$clog2(NUM_OF_BANKS)-1:0]       bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]        row_id,
  output logic [$clog2(NUM_OF_COLS)-1:0]        col_id,
  output logic [L2_REQ_WIDTH-ADDR_WIDTH-1:0]    offset,
  output logic                                  row_hit,
  output logic [$clog2(FIFO_DEPTH):0]           pending_cnt
);

  localparam int unsigned BankW = $clog2(NUM_OF_BANKS);
  localparam int unsigned RowW  = $clog2(NUM_OF_ROWS);
  localparam int unsigned ColW  = $clog2(NUM_OF_COLS);
  localparam int unsigned OffW  = L2_REQ_WIDTH - ADDR_WIDTH;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [L2_REQ_WIDTH-1:0] fifo_rdata;

  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [BankW-1:0]        head_bank;
  logic [RowW-1:0]         head_row;
  logic [ColW-1:0]         head_col;
  logic [OffW-1:0]         head_off;

  state_e                  state_q, state_d;
  logic                    eligible_q, eligible_d;
  logic [BankW-1:0]        bank_q, bank_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [OffW-1:0]         off_q, off_d;

  assign l2_req_ready = !fifo_full;
  assign fifo_push    = l2_req_valid && !fifo_full;

  dram_req_fifo #(
    .Width (L2_REQ_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (l2_req_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_cnt)
  );

  assign head_addr = fifo_rdata[OffW +: ADDR_WIDTH];
  assign head_off  = fifo_rdata[OffW-1:0];
  assign head_bank = head_addr[BANK_LSB +: BankW];
  assign head_row  = head_addr[ROW_LSB +: RowW];
  assign head_col  = head_addr[COL_LSB +: ColW];

  // A request landing in an empty queue becomes issuable one cycle later,
  // which fixes request-to-addr_val latency at two edges.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    eligible_d = !fifo_empty;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    off_d      = off_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && eligible_q && !refresh_flag) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
          bank_d   = head_bank;
          row_d    = head_row;
          col_d    = head_col;
          off_d    = head_off;
        end
      end
      ISSUE: begin
        if (ctrl_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      eligible_q <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      eligible_q <= eligible_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      off_q      <= off_d;
    end
  end

  assign addr_val = (state_q == ISSUE);
  assign bank_id  = bank_q;
  assign row_id   = row_q;
  assign col_id   = col_q;
  assign offset   = off_q;

`ifdef DRAM_REQ_ROW_HIT_EN
  logic [RowW-1:0]         open_row_q [NUM_OF_BANKS];
  logic [RowW-1:0]         open_row_d [NUM_OF_BANKS];
  logic [NUM_OF_BANKS-1:0] row_vld_q, row_vld_d;
  logic                    row_hit_q, row_hit_d;

  always_comb begin
    open_row_d = open_row_q;
    row_vld_d  = row_vld_q;
    row_hit_d  = row_hit_q;
    // Refresh closes every row, even one being acknowledged this cycle.
    if (refresh_flag) begin
      row_vld_d = '0;
    end else if ((state_q == ISSUE) && ctrl_ack) begin
      row_vld_d[bank_q]  = 1'b1;
      open_row_d[bank_q] = row_q;
    end
    if (fifo_pop) begin
      row_hit_d = row_vld_q[head_bank] && (open_row_q[head_bank] == head_row);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_vld_q <= '0;
      row_hit_q <= 1'b0;
    end else begin
      row_vld_q <= row_vld_d;
      row_hit_q <= row_hit_d;
    end
  end

  // Row contents are qualified by row_vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    open_row_q <= open_row_d;
  end

  assign row_hit = row_hit_q;
`else
  assign row_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dram_req_frontend.sv
// tb_dram_req_frontend: directed and randomized checks of dram_req_frontend
// against a queue-based reference model. Honors DRAM_REQ_ROW_HIT_EN.
module tb_dram_req_frontend;

  localparam int unsigned Depth = 4;
`ifdef DRAM_REQ_ROW_HIT_EN
  localparam bit HitEn = 1'b1;
`else
  localparam bit HitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        l2_req_valid;
  logic [21:0] l2_req_data;
  logic        l2_req_ready;
  logic        refresh_flag;
  logic        addr_val;
  logic        ctrl_ack;
  logic [2:0]  bank_id;
  logic [6:0]  row_id;
  logic [2:0]  col_id;
  logic [8:0]  offset;
  logic        row_hit;
  logic [2:0]  pending_cnt;

  always #5 clk = ~clk;

  dram_req_frontend dut (
    .clk          (clk),
    .rst          (rst),
    .l2_req_valid (l2_req_valid),
    .l2_req_data  (l2_req_data),
    .l2_req_ready (l2_req_ready),
    .refresh_flag (refresh_flag),
    .addr_val     (addr_val),
    .ctrl_ack     (ctrl_ack),
    .bank_id      (bank_id),
    .row_id       (row_id),
    .col_id       (col_id),
    .offset       (offset),
    .row_hit      (row_hit),
    .pending_cnt  (pending_cnt)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  logic [21:0] mq [$];          // queued, not yet presented
  logic        pres_valid;      // a request is being presented
  logic [21:0] pres_data;
  logic        pres_hit;
  logic        pres_known;      // row-hit expectation is defined
  int          sz_hist;         // queue size before the previous edge
  logic [6:0]  open_row [8];
  logic [7:0]  open_vld;
  logic        known;           // open-row model synced by a refresh

  function automatic int f_bank(input logic [21:0] d);
    return int'((d >> 19) & 22'h7);
  endfunction
  function automatic int f_row(input logic [21:0] d);
    return int'((d >> 12) & 22'h7F);
  endfunction
  function automatic int f_col(input logic [21:0] d);
    return int'((d >> 9) & 22'h7);
  endfunction
  function automatic int f_off(input logic [21:0] d);
    return int'(d & 22'h1FF);
  endfunction

  function automatic logic [21:0] mk_req(input int bank, input int row, input int col,
                                         input int off);
    return 22'((bank << 19) + (row << 12) + (col << 9) + off);
  endfunction

  function automatic logic [21:0] rand_req();
    return mk_req(int'($urandom_range(7)), ($urandom_range(1) != 0) ? 'h10 : 'h11,
                  int'($urandom_range(7)), int'($urandom_range(511)));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare every observable output.
  task automatic step(input logic v, input logic [21:0] d, input logic a, input logic r);
    int          s0;
    logic        was_val, push_exp, issue_exp, exp_val, nxt_hit;
    logic [21:0] nxt;
    l2_req_valid = v;
    l2_req_data  = d;
    ctrl_ack     = a;
    refresh_flag = r;
    s0        = mq.size();
    was_val   = pres_valid;
    push_exp  = v && (s0 < Depth);
    issue_exp = !was_val && !r && (s0 > 0) && (sz_hist > 0);
    nxt       = '0;
    nxt_hit   = 1'b0;
    if (issue_exp) begin
      nxt     = mq[0];
      nxt_hit = open_vld[f_bank(nxt)] && (int'(open_row[f_bank(nxt)]) == f_row(nxt));
    end
    @(posedge clk);
    #1;
    if (r) begin
      open_vld = '0;
      known    = 1'b1;
    end else if (was_val && a) begin
      open_vld[f_bank(pres_data)] = 1'b1;
      open_row[f_bank(pres_data)] = 7'(f_row(pres_data));
    end
    if (was_val && a) pres_valid = 1'b0;
    if (issue_exp) begin
      void'(mq.pop_front());
      pres_data  = nxt;
      pres_hit   = nxt_hit;
      pres_known = known;
      pres_valid = 1'b1;
    end
    if (push_exp) mq.push_back(d);
    sz_hist = s0;
    exp_val = was_val ? !a : issue_exp;
    check("addr_val", int'(addr_val), int'(exp_val));
    check("pending_cnt", int'(pending_cnt), mq.size());
    check("l2_req_ready", int'(l2_req_ready), int'(mq.size() < Depth));
    if (pres_valid) begin
      check("bank_id", int'(bank_id), f_bank(pres_data));
      check("row_id", int'(row_id), f_row(pres_data));
      check("col_id", int'(col_id), f_col(pres_data));
      check("offset", int'(offset), f_off(pres_data));
      if (!HitEn) check("row_hit_off", int'(row_hit), 0);
      else if (pres_known) check("row_hit", int'(row_hit), int'(pres_hit));
    end
  endtask

  task automatic do_reset(input logic v);
    rst          = 1'b1;
    l2_req_valid = v;
    l2_req_data  = rand_req();
    ctrl_ack     = 1'b0;
    refresh_flag = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    pres_valid = 1'b0;
    sz_hist    = 0;
    known      = 1'b0;
    check("rst_addr_val", int'(addr_val), 0);
    check("rst_pending", int'(pending_cnt), 0);
    check("rst_ready", int'(l2_req_ready), 1);
    check("rst_fields", int'({bank_id, row_id, col_id, offset}), 0);
    check("rst_row_hit", int'(row_hit), 0);
    rst          = 1'b0;
    l2_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && !pres_valid) break;
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_pending", int'(pending_cnt), 0);
    check("drain_addr_val", int'(addr_val), 0);
  endtask

  task automatic issue_and_ack(input logic [21:0] d, input int exp_hit, input logic ack_ref);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("hit_issue", int'(addr_val), 1);
    check("hit_value", int'(row_hit), exp_hit);
    step(1'b0, '0, 1'b1, ack_ref);
  endtask

  initial begin
    logic [21:0] wd [10];
    int          pushed;
    logic        can;
    pres_valid = 1'b0;
    pres_data  = '0;
    pres_hit   = 1'b0;
    pres_known = 1'b0;
    sz_hist    = 0;
    open_vld   = '0;
    known      = 1'b0;
    for (int i = 0; i < 8; i++) open_row[i] = '0;

    // Reset with a request presented: it must not be queued
    do_reset(1'b1);
    do_reset(1'b1);
    step(1'b0, '0, 1'b1, 1'b0);  // ack while idle is ignored
    step(1'b0, '0, 1'b0, 1'b0);

    // Single request, two-edge latency and field decode
    step(1'b1, {13'h152A, 9'h0F3}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("single_val", int'(addr_val), 1);
    check("single_bank", int'(bank_id), 5);
    check("single_row", int'(row_id), 'h25);
    check("single_col", int'(col_id), 2);
    check("single_off", int'(offset), 'h0F3);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: fill the queue while the head waits for ack
    for (int i = 0; i < 4; i++) step(1'b1, mk_req(i, i + 1, i, 16 * i + 1), 1'b0, 1'b0);
    check("bp_pending3", int'(pending_cnt), 3);
    check("bp_ready_hi", int'(l2_req_ready), 1);
    step(1'b1, mk_req(7, 'h7F, 7, 'h1FF), 1'b0, 1'b0);
    check("bp_pending4", int'(pending_cnt), 4);
    check("bp_ready_lo", int'(l2_req_ready), 0);
    step(1'b1, mk_req(6, 6, 6, 6), 1'b0, 1'b0);  // refused: queue full
    drain();

    // Refresh blocks issue; raising it during ISSUE keeps addr_val
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, mk_req(1, 2, 3, 4), 1'b0, 1'b1);
    step(1'b1, mk_req(2, 3, 4, 5), 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    check("ref_blocked", int'(addr_val), 0);
    check("ref_pending", int'(pending_cnt), 2);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ref_resume", int'(addr_val), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ref_hold", int'(addr_val), 1);
    drain();

    // Reset while issuing with three queued
    for (int i = 0; i < 4; i++) step(1'b1, mk_req(3, i, 1, i), 1'b0, 1'b0);
    check("mid_val", int'(addr_val), 1);
    check("mid_pending", int'(pending_cnt), 3);
    do_reset(1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);

    // Row-hit tracking on bank 3
    step(1'b0, '0, 1'b0, 1'b1);
    issue_and_ack(mk_req(3, 'h10, 0, 1), 0, 1'b0);
    issue_and_ack(mk_req(3, 'h10, 1, 2), int'(HitEn), 1'b0);
    issue_and_ack(mk_req(3, 'h11, 2, 3), 0, 1'b0);
    issue_and_ack(mk_req(3, 'h11, 3, 4), int'(HitEn), 1'b0);
    issue_and_ack(mk_req(3, 'h10, 4, 5), 0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    issue_and_ack(mk_req(3, 'h10, 5, 6), 0, 1'b1);  // refresh coincides with ack
    issue_and_ack(mk_req(3, 'h10, 6, 7), 0, 1'b0);

    // Ten back-to-back requests with ack held high (pointer wrap)
    for (int i = 0; i < 10; i++) wd[i] = rand_req();
    pushed = 0;
    for (int i = 0; i < 60 && pushed < 10; i++) begin
      can = (mq.size() < Depth);
      step(1'b1, wd[pushed], 1'b1, 1'b0);
      if (can) pushed++;
    end
    check("wrap_pushed", pushed, 10);
    drain();

    // Randomized traffic
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 60, rand_req(), $urandom_range(1) != 0,
           $urandom_range(99) < 8);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
